// File: rtl/ysyx_23060236_burst_rsp.sv
// AXI4 read responder for IFU bursts backed by an on-chip word memory.
// Single read channel, configurable first-beat latency, backdoor load port.
module ysyx_23060236_burst_rsp #(
   parameter logic [31:0] BASE_ADDR  = 32'h30000000,
   parameter int          DEPTH_LOG2 = 10,
   parameter int          LATENCY    = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           araddr,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [1:0]            arburst,
   input  logic [3:0]            arlen,
   output logic [31:0]           rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic                  ld_en,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [31:0]           ld_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_BEAT
   } state_e;

   localparam int          NWORDS = 1 << DEPTH_LOG2;
   localparam logic [32:0] LIMIT  = 33'(1) << (DEPTH_LOG2 + 2);
   localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_SLV   = 2'b10;
   localparam logic [1:0] RESP_DEC   = 2'b11;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  burst_q, burst_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  lat_q, lat_d;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic        rlast_q;

   logic [31:0] mem_q [NWORDS];

   logic        load_w;
   logic [31:0] beat_addr_w;
   logic [1:0]  beat_burst_w;
   logic        beat_last_w;
   logic [31:0] beat_off_w;
   logic        beat_in_w;
   logic [31:0] beat_data_w;
   logic [1:0]  beat_resp_w;

   assign arready = (state_q == S_IDLE);
   assign rvalid  = (state_q == S_BEAT);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rlast   = rlast_q;

   // Sequencer: accept AR, count latency, step through beats on handshake.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      burst_d      = burst_q;
      cnt_d        = cnt_q;
      lat_d        = lat_q;
      load_w       = 1'b0;
      beat_addr_w  = addr_q;
      beat_burst_w = burst_q;
      beat_last_w  = (cnt_q == 4'd0);
      unique case (state_q)
         S_IDLE: begin
            if (arvalid) begin
               addr_d  = araddr;
               burst_d = arburst;
               cnt_d   = arlen;
               if (LATENCY == 0) begin
                  state_d      = S_BEAT;
                  load_w       = 1'b1;
                  beat_addr_w  = araddr;
                  beat_burst_w = arburst;
                  beat_last_w  = (arlen == 4'd0);
               end else begin
                  lat_d   = LAT_M1;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (lat_q == 4'd0) begin
               state_d = S_BEAT;
               load_w  = 1'b1;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         S_BEAT: begin
            if (rready) begin
               if (rlast_q) begin
                  state_d = S_IDLE;
               end else begin
                  if (burst_q == BURST_INCR) begin
                     addr_d = addr_q + 32'd4;
                  end
                  cnt_d       = cnt_q - 4'd1;
                  load_w      = 1'b1;
                  beat_addr_w = addr_d;
                  beat_last_w = (cnt_q == 4'd1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Per-beat response: burst type first, then address range, then data.
   always_comb begin
      beat_off_w  = beat_addr_w - BASE_ADDR;
      beat_in_w   = ({1'b0, beat_off_w} < LIMIT);
      beat_data_w = 32'd0;
      beat_resp_w = RESP_OKAY;
      if (beat_burst_w[1]) begin
         beat_resp_w = RESP_SLV;
      end else if (!beat_in_w) begin
         beat_resp_w = RESP_DEC;
      end else begin
         beat_data_w = mem_q[beat_off_w[DEPTH_LOG2+1:2]];
      end
   end

   // Control and beat registers; a beat is captured whenever load_w fires.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         addr_q  <= 32'd0;
         burst_q <= 2'b00;
         cnt_q   <= 4'd0;
         lat_q   <= 4'd0;
         rdata_q <= 32'd0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         if (load_w) begin
            rdata_q <= beat_data_w;
            rresp_q <= beat_resp_w;
            rlast_q <= beat_last_w;
         end
      end
   end

   // Backdoor image load; beat capture in the same edge sees the old word.
   always_ff @(posedge clock) begin
      if (ld_en) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

endmodule

// File: tb/tb_ysyx_23060236_burst_rsp.sv
// Bench for ysyx_23060236_burst_rsp: directed scenarios plus random bursts
// checked against an array-based memory/response model.
module tb_ysyx_23060236_burst_rsp;

   localparam logic [31:0] BASE = 32'h30000000;
   localparam int          D    = 10;
   localparam int          LAT  = 2;
   localparam int          NW   = 1 << D;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   araddr = '0;
   logic          arvalid = 1'b0;
   logic          arready;
   logic [1:0]    arburst = '0;
   logic [3:0]    arlen = '0;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready = 1'b0;
   logic          ld_en = 1'b0;
   logic [D-1:0]  ld_addr = '0;
   logic [31:0]   ld_data = '0;

   always #5 clock = ~clock;

   ysyx_23060236_burst_rsp #(
      .BASE_ADDR (BASE),
      .DEPTH_LOG2(D),
      .LATENCY   (LAT)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .araddr (araddr),
      .arvalid(arvalid),
      .arready(arready),
      .arburst(arburst),
      .arlen  (arlen),
      .rdata  (rdata),
      .rresp  (rresp),
      .rlast  (rlast),
      .rvalid (rvalid),
      .rready (rready),
      .ld_en  (ld_en),
      .ld_addr(ld_addr),
      .ld_data(ld_data)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [NW];

   logic [31:0] c_data[$];
   logic [1:0]  c_resp[$];
   logic        c_last[$];
   int          c_rel[$];
   int          c_timeout;
   int          c_unstable;
   int          c_drop;
   int          c_busy;
   int          c_first;
   int          c_ar_rel;
   logic        c_ar_after;

   // expected {resp, data} of beat k, straight from the address rules
   function automatic logic [33:0] model(input logic [31:0] a,
                                         input logic [1:0] b,
                                         input int k);
      logic [31:0] ad;
      logic [31:0] off;
      ad  = {a[31:2], 2'b00};
      if (b == 2'b01) ad = ad + 32'(4 * k);
      off = ad - BASE;
      if (b[1]) return {2'b10, 32'h0};
      if (off >= 32'(4 * NW)) return {2'b11, 32'h0};
      return {2'b00, mem_m[off >> 2]};
   endfunction

   task automatic load_word(input int idx, input logic [31:0] val);
      @(negedge clock);
      ld_en   = 1'b1;
      ld_addr = idx[D-1:0];
      ld_data = val;
      mem_m[idx] = val;
      @(negedge clock);
      ld_en = 1'b0;
   endtask

   // issues one AR and collects handshaked beats; no checking here
   task automatic issue(input logic [31:0] a, input logic [1:0] b,
                        input logic [3:0] l, input int rmode,
                        input int ld_rel, input int ld_idx,
                        input logic [31:0] ld_val);
      int   rel;
      int   vcnt;
      logic done;
      logic stall;
      logic rr;
      logic [31:0] pd;
      logic [1:0]  pr;
      logic        pl;
      c_data.delete();
      c_resp.delete();
      c_last.delete();
      c_rel.delete();
      c_timeout  = 0;
      c_unstable = 0;
      c_drop     = 0;
      c_busy     = 0;
      c_first    = -1;
      rel   = 0;
      vcnt  = 0;
      done  = 1'b0;
      stall = 1'b0;
      pd = '0;
      pr = '0;
      pl = 1'b0;
      @(negedge clock);
      araddr  = a;
      arburst = b;
      arlen   = l;
      arvalid = 1'b1;
      rready  = 1'b0;
      @(posedge clock);
      while (!done && rel < 300) begin
         @(negedge clock);
         rel++;
         arvalid = 1'b0;
         ld_en   = (rel == ld_rel);
         ld_addr = ld_idx[D-1:0];
         ld_data = ld_val;
         if (arready) c_busy++;
         if (stall) begin
            if (!rvalid) c_drop++;
            else if (rdata !== pd || rresp !== pr || rlast !== pl)
               c_unstable++;
         end
         if (rvalid) begin
            if (c_first < 0) c_first = rel;
            if (rmode == 0) rr = 1'b1;
            else if (rmode == 1) rr = (vcnt % 3 == 0);
            else rr = 1'($urandom_range(0, 1));
            vcnt++;
            rready = rr;
            stall  = !rr;
            pd = rdata;
            pr = rresp;
            pl = rlast;
            if (rr) begin
               c_data.push_back(rdata);
               c_resp.push_back(rresp);
               c_last.push_back(rlast);
               c_rel.push_back(rel);
               if (rlast) done = 1'b1;
            end
         end else begin
            rready = 1'b0;
            stall  = 1'b0;
         end
      end
      if (!done) c_timeout = 1;
      @(negedge clock);
      ld_en      = 1'b0;
      rready     = 1'b0;
      c_ar_after = arready;
      c_ar_rel   = rel + 1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      total++;
      if (arready !== 1'b1) begin
         bad++; $display("FAIL reset_arready got %b want 1", arready);
      end
      total++;
      if (rvalid !== 1'b0) begin
         bad++; $display("FAIL reset_rvalid got %b want 0", rvalid);
      end
      total++;
      if (rlast !== 1'b0 || rresp !== 2'b00 || rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_beat got %b/%h/%h want 0/0/0",
                  rlast, rresp, rdata);
      end
      reset = 1'b1;
      for (int i = 0; i < NW; i++) begin
         @(negedge clock);
         ld_en   = 1'b1;
         ld_addr = i[D-1:0];
         ld_data = 32'(i) * 32'h11111111;
         mem_m[i] = 32'(i) * 32'h11111111;
      end
      @(negedge clock);
      ld_en = 1'b0;
   endtask

   task automatic test_incr();
      logic [33:0] e;
      issue(BASE + 32'h20, 2'b01, 4'd7, 0, -1, 0, 32'h0);
      total++;
      if (c_timeout != 0 || c_data.size() != 8) begin
         bad++;
         $display("FAIL incr_count got %0d want 8", c_data.size());
      end
      for (int k = 0; k < c_data.size(); k++) begin
         e = model(BASE + 32'h20, 2'b01, k);
         total++;
         if (c_data[k] !== e[31:0] || c_resp[k] !== 2'b00) begin
            bad++;
            $display("FAIL incr_beat%0d got %h/%h want %h/00",
                     k, c_data[k], c_resp[k], e[31:0]);
         end
         total++;
         if (c_rel[k] != 1 + LAT + k || c_last[k] !== (k == 7)) begin
            bad++;
            $display("FAIL incr_time%0d got t%0d last%b want t%0d last%b",
                     k, c_rel[k], c_last[k], 1 + LAT + k, k == 7);
         end
      end
      total++;
      if (c_ar_after !== 1'b1 || c_ar_rel != 11 || c_busy != 0) begin
         bad++;
         $display("FAIL incr_arready got %b@%0d busy%0d want 1@11 busy0",
                  c_ar_after, c_ar_rel, c_busy);
      end
   endtask

   task automatic test_stall();
      logic [33:0] e;
      issue(BASE + 32'h20, 2'b01, 4'd7, 1, -1, 0, 32'h0);
      total++;
      if (c_timeout != 0 || c_data.size() != 8) begin
         bad++;
         $display("FAIL stall_count got %0d want 8", c_data.size());
      end
      for (int k = 0; k < c_data.size(); k++) begin
         e = model(BASE + 32'h20, 2'b01, k);
         total++;
         if (c_data[k] !== e[31:0] || c_last[k] !== (k == 7)) begin
            bad++;
            $display("FAIL stall_beat%0d got %h last%b want %h last%b",
                     k, c_data[k], c_last[k], e[31:0], k == 7);
         end
      end
      total++;
      if (c_unstable != 0 || c_drop != 0) begin
         bad++;
         $display("FAIL stall_hold got unstable%0d drop%0d want 0 0",
                  c_unstable, c_drop);
      end
   endtask

   task automatic test_boundary();
      logic [31:0] a;
      logic [1:0]  want_r [4];
      a = BASE + 32'(4 * (NW - 2));
      want_r = '{2'b00, 2'b00, 2'b11, 2'b11};
      issue(a, 2'b01, 4'd3, 0, -1, 0, 32'h0);
      total++;
      if (c_data.size() != 4) begin
         bad++;
         $display("FAIL bound_count got %0d want 4", c_data.size());
      end
      for (int k = 0; k < c_data.size() && k < 4; k++) begin
         total++;
         if (c_resp[k] !== want_r[k] ||
             c_data[k] !== (k < 2 ? mem_m[NW - 2 + k] : 32'h0)) begin
            bad++;
            $display("FAIL bound_beat%0d got %h/%h want %h", k,
                     c_resp[k], c_data[k], want_r[k]);
         end
      end
   endtask

   task automatic test_slverr_fixed();
      issue(BASE, 2'b10, 4'd1, 0, -1, 0, 32'h0);
      total++;
      if (c_data.size() != 2) begin
         bad++;
         $display("FAIL slv_count got %0d want 2", c_data.size());
      end
      for (int k = 0; k < c_data.size(); k++) begin
         total++;
         if (c_resp[k] !== 2'b10 || c_data[k] !== 32'h0 ||
             c_last[k] !== (k == 1)) begin
            bad++;
            $display("FAIL slv_beat%0d got %h/%h/%b want 10/0/%b", k,
                     c_resp[k], c_data[k], c_last[k], k == 1);
         end
      end
      issue(BASE + 32'h8, 2'b00, 4'd2, 0, -1, 0, 32'h0);
      total++;
      if (c_data.size() != 3) begin
         bad++;
         $display("FAIL fixed_count got %0d want 3", c_data.size());
      end
      for (int k = 0; k < c_data.size(); k++) begin
         total++;
         if (c_resp[k] !== 2'b00 || c_data[k] !== mem_m[2]) begin
            bad++;
            $display("FAIL fixed_beat%0d got %h/%h want 00/%h", k,
                     c_resp[k], c_data[k], mem_m[2]);
         end
      end
   endtask

   task automatic test_rbw();
      logic [33:0] e;
      logic [31:0] want [8];
      for (int k = 0; k < 8; k++) begin
         e = model(BASE + 32'h20, 2'b01, k);
         want[k] = e[31:0];
      end
      issue(BASE + 32'h20, 2'b01, 4'd7, 0, 1 + LAT, 9, 32'hDEADBEEF);
      mem_m[9] = 32'hDEADBEEF;
      total++;
      if (c_data.size() != 8) begin
         bad++;
         $display("FAIL rbw_count got %0d want 8", c_data.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            total++;
            if (c_data[k] !== want[k]) begin
               bad++;
               $display("FAIL rbw_beat%0d got %h want %h", k,
                        c_data[k], want[k]);
            end
         end
      end
      issue(BASE + 32'h24, 2'b01, 4'd0, 0, -1, 0, 32'h0);
      total++;
      if (c_data.size() != 1 || c_data[0] !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL rbw_reread got %h want deadbeef",
                  c_data.size() > 0 ? c_data[0] : 32'hx);
      end
   endtask

   task automatic test_mid_reset();
      int   hs;
      int   stray;
      logic hit;
      load_word(0, 32'hA5A50001);
      @(negedge clock);
      araddr  = BASE;
      arburst = 2'b01;
      arlen   = 4'd7;
      arvalid = 1'b1;
      rready  = 1'b1;
      @(posedge clock);
      hs  = 0;
      hit = 1'b0;
      for (int n = 0; n < 60 && !hit; n++) begin
         @(negedge clock);
         arvalid = 1'b0;
         if (rvalid) begin
            if (hs == 3) begin
               reset = 1'b0;
               hit   = 1'b1;
            end else begin
               hs++;
            end
         end
      end
      total++;
      if (!hit) begin
         bad++; $display("FAIL mreset_reach got %0d beats want 3", hs);
      end
      @(negedge clock);
      total++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         bad++;
         $display("FAIL mreset_out got rvalid%b arready%b want 0 1",
                  rvalid, arready);
      end
      total++;
      if (rlast !== 1'b0 || rresp !== 2'b00 || rdata !== 32'h0) begin
         bad++;
         $display("FAIL mreset_beat got %b/%h/%h want 0/0/0",
                  rlast, rresp, rdata);
      end
      reset = 1'b1;
      stray = 0;
      repeat (4) begin
         @(negedge clock);
         if (rvalid) stray++;
      end
      rready = 1'b0;
      total++;
      if (stray != 0) begin
         bad++; $display("FAIL mreset_stray got %0d want 0", stray);
      end
      issue(BASE, 2'b01, 4'd0, 0, -1, 0, 32'h0);
      total++;
      if (c_data.size() != 1 || c_resp[0] !== 2'b00 ||
          c_last[0] !== 1'b1 || c_data[0] !== mem_m[0]) begin
         bad++;
         $display("FAIL mreset_new got n%0d want 1 okay beat %h",
                  c_data.size(), mem_m[0]);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [1:0]  b;
      logic [3:0]  l;
      logic [33:0] e;
      int          sel;
      for (int it = 0; it < 30; it++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: a = BASE + 32'(4 * $urandom_range(0, NW - 1))
                        + 32'($urandom_range(0, 3));
            1: a = BASE + 32'(4 * (NW - $urandom_range(0, 8)));
            2: a = BASE - 32'(4 * $urandom_range(1, 8));
            default: a = $urandom;
         endcase
         b = 2'($urandom_range(0, 3));
         l = 4'($urandom_range(0, 15));
         issue(a, b, l, 2, -1, 0, 32'h0);
         total++;
         if (c_timeout != 0 || c_data.size() != int'(l) + 1 ||
             c_first != 1 + LAT || c_busy != 0 ||
             c_unstable != 0 || c_drop != 0 || c_ar_after !== 1'b1) begin
            bad++;
            $display("FAIL rand%0d_frame got n%0d first%0d busy%0d u%0d d%0d want n%0d first%0d",
                     it, c_data.size(), c_first, c_busy, c_unstable,
                     c_drop, int'(l) + 1, 1 + LAT);
         end
         for (int k = 0; k < c_data.size(); k++) begin
            e = model(a, b, k);
            total++;
            if (c_data[k] !== e[31:0] || c_resp[k] !== e[33:32] ||
                c_last[k] !== (k == int'(l))) begin
               bad++;
               $display("FAIL rand%0d_beat%0d got %h/%h/%b want %h/%h/%b",
                        it, k, c_resp[k], c_data[k], c_last[k],
                        e[33:32], e[31:0], k == int'(l));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_stall();
      test_boundary();
      test_slverr_fixed();
      test_rbw();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
